// File: rtl/button_step_debouncer.sv
// Push-button conditioner: synchronizes and debounces a raw button level and
// emits single-cycle step pulses on each accepted press, with optional auto-repeat.
module button_step_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 5000,
    parameter int REPEAT_PERIOD   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic step,
    output logic pressed,
    output logic repeating
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam bit REP_EN  = (REPEAT_DELAY > 0);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_SAT     = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD);
    localparam logic [REP_W-1:0] REP_SAT    = REP_W'(REP_MAX);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, btn_s_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              step_q, step_d;
    logic              pressed_q, pressed_d;
    logic              repeating_q, repeating_d;
    logic              db_done;
    logic              rep_hit;

    function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
        return (v == DB_SAT) ? v : v + 1'b1;
    endfunction

    function automatic logic [REP_W-1:0] rep_inc(input logic [REP_W-1:0] v);
        return (v == REP_SAT) ? v : v + 1'b1;
    endfunction

    assign db_done = (db_cnt_q == DB_LAST);
    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    assign rep_hit = repeating_q ? (rep_cnt_q == REP_PERIOD) : (rep_cnt_q == REP_DELAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            btn_s_q     <= 1'b0;
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            step_q      <= 1'b0;
            pressed_q   <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            sync1_q     <= btn_in;
            btn_s_q     <= sync1_q;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            step_q      <= step_d;
            pressed_q   <= pressed_d;
            repeating_q <= repeating_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (btn_s_q) state_d = PRESS_DB;
            PRESS_DB: begin
                if (!btn_s_q)     state_d = IDLE;
                else if (db_done) state_d = HELD;
            end
            HELD:       if (!btn_s_q) state_d = RELEASE_DB;
            RELEASE_DB: begin
                if (btn_s_q)      state_d = HELD;
                else if (db_done) state_d = IDLE;
            end
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        db_cnt_d    = db_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        step_d      = 1'b0;
        pressed_d   = pressed_q;
        repeating_d = repeating_q;
        case (state_q)
            IDLE: begin
                db_cnt_d    = btn_s_q ? DB_W'(1) : '0;
                rep_cnt_d   = '0;
                pressed_d   = 1'b0;
                repeating_d = 1'b0;
            end
            PRESS_DB: begin
                if (!btn_s_q) begin
                    db_cnt_d = '0;
                end else if (db_done) begin
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                    step_d    = 1'b1;
                    pressed_d = 1'b1;
                end else begin
                    db_cnt_d = db_inc(db_cnt_q);
                end
            end
            HELD: begin
                if (!btn_s_q) begin
                    db_cnt_d = DB_W'(1);
                end else if (REP_EN) begin
                    if (rep_hit) begin
                        step_d      = 1'b1;
                        repeating_d = 1'b1;
                        rep_cnt_d   = '0;
                    end else begin
                        rep_cnt_d = rep_inc(rep_cnt_q);
                    end
                end
            end
            RELEASE_DB: begin
                // Repeat timing is frozen here so a short release glitch only delays it.
                if (btn_s_q) begin
                    db_cnt_d = '0;
                end else if (db_done) begin
                    db_cnt_d    = '0;
                    rep_cnt_d   = '0;
                    pressed_d   = 1'b0;
                    repeating_d = 1'b0;
                end else begin
                    db_cnt_d = db_inc(db_cnt_q);
                end
            end
            default: begin
                db_cnt_d    = '0;
                rep_cnt_d   = '0;
                pressed_d   = 1'b0;
                repeating_d = 1'b0;
            end
        endcase
    end

    assign step      = step_q;
    assign pressed   = pressed_q;
    assign repeating = repeating_q;

endmodule

// File: tb/tb_button_step_debouncer.sv
// Bench for button_step_debouncer: directed scenarios with fixed expected pulse
// positions plus randomized button activity compared against a behavioural model.
module tb_button_step_debouncer;

    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic step, pressed, repeating;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    button_step_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .step(step),
        .pressed(pressed),
        .repeating(repeating)
    );

    // Reference: two-sample delay line, a run length of samples disagreeing with
    // the accepted level, and a repeat timer measured in fully-held cycles.
    logic m_s1 = 0, m_s2 = 0, m_pressed = 0, m_rep = 0, e_step = 0;
    int   m_run = 0, m_timer = 0;

    always @(posedge clk) begin
        bit bs;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_pressed = 0; m_rep = 0; e_step = 0;
            m_run = 0; m_timer = 0;
        end else begin
            bs = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_in;
            e_step = 0;
            if (!m_pressed) begin
                m_run = bs ? m_run + 1 : 0;
                if (m_run == DC) begin
                    m_pressed = 1; e_step = 1; m_timer = 0; m_run = 0;
                end
            end else if (!bs) begin
                m_run = m_run + 1;
                if (m_run == DC) begin
                    m_pressed = 0; m_rep = 0; m_timer = 0; m_run = 0;
                end
            end else if (m_run > 0) begin
                m_run = 0;
            end else if (RD > 0) begin
                if (m_timer == (m_rep ? RP : RD)) begin
                    e_step = 1; m_rep = 1; m_timer = 0;
                end else begin
                    m_timer = m_timer + 1;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1; btn_in = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            tests++;
            if ({step, pressed, repeating} !== 3'b000) begin
                fails++;
                $display("FAIL reset_outputs cyc %0d: got %b%b%b expected 000", c, step, pressed, repeating);
            end
        end
        rst = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            tests++;
            if (step !== (c == 6)) begin
                fails++;
                $display("FAIL reset_step cyc %0d: got %b expected %b", c, step, (c == 6));
            end
            tests++;
            if ({step, pressed, repeating} !== {e_step, m_pressed, m_rep}) begin
                fails++;
                $display("FAIL reset_model cyc %0d: got %b%b%b expected %b%b%b", c, step, pressed, repeating, e_step, m_pressed, m_rep);
            end
            if (c == 12) btn_in = 0;
        end
    endtask

    task automatic test_clean_press();
        int pcount = 0;
        btn_in = 1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (pressed === 1'b1) pcount++;
            tests++;
            if (step !== (c == 6)) begin
                fails++;
                $display("FAIL clean_step cyc %0d: got %b expected %b", c, step, (c == 6));
            end
            tests++;
            if ({step, pressed, repeating} !== {e_step, m_pressed, m_rep}) begin
                fails++;
                $display("FAIL clean_model cyc %0d: got %b%b%b expected %b%b%b", c, step, pressed, repeating, e_step, m_pressed, m_rep);
            end
            if (c == 10) btn_in = 0;
        end
        tests++;
        if (pcount !== 10) begin
            fails++;
            $display("FAIL clean_pressed_len: got %0d cycles expected 10", pcount);
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat = 6'b101101;  // pat[0] first: 1,0,1,1,0,1
        btn_in = pat[0];
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            tests++;
            if (step !== (c == 11)) begin
                fails++;
                $display("FAIL bounce_step cyc %0d: got %b expected %b", c, step, (c == 11));
            end
            tests++;
            if ({step, pressed, repeating} !== {e_step, m_pressed, m_rep}) begin
                fails++;
                $display("FAIL bounce_model cyc %0d: got %b%b%b expected %b%b%b", c, step, pressed, repeating, e_step, m_pressed, m_rep);
            end
            if (c < 6) btn_in = pat[c];
            if (c == 20) btn_in = 0;
        end
    endtask

    task automatic test_hold_repeat();
        btn_in = 1;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            tests++;
            if (step !== (c == 6 || c == 27 || c == 36 || c == 45 || c == 54)) begin
                fails++;
                $display("FAIL hold_step cyc %0d: got %b", c, step);
            end
            tests++;
            if (repeating !== (c >= 27 && c < 66)) begin
                fails++;
                $display("FAIL hold_repeating cyc %0d: got %b expected %b", c, repeating, (c >= 27 && c < 66));
            end
            tests++;
            if ({step, pressed, repeating} !== {e_step, m_pressed, m_rep}) begin
                fails++;
                $display("FAIL hold_model cyc %0d: got %b%b%b expected %b%b%b", c, step, pressed, repeating, e_step, m_pressed, m_rep);
            end
            if (c == 60) btn_in = 0;
        end
    endtask

    task automatic test_glitch();
        btn_in = 1;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            tests++;
            if (step !== (c == 6 || c == 27 || c == 36 || c == 48 || c == 57)) begin
                fails++;
                $display("FAIL glitch_step cyc %0d: got %b", c, step);
            end
            tests++;
            if ({pressed, repeating} !== {(c >= 6 && c < 66), (c >= 27 && c < 66)}) begin
                fails++;
                $display("FAIL glitch_levels cyc %0d: got %b%b expected %b%b", c, pressed, repeating, (c >= 6 && c < 66), (c >= 27 && c < 66));
            end
            tests++;
            if ({step, pressed, repeating} !== {e_step, m_pressed, m_rep}) begin
                fails++;
                $display("FAIL glitch_model cyc %0d: got %b%b%b expected %b%b%b", c, step, pressed, repeating, e_step, m_pressed, m_rep);
            end
            if (c == 40) btn_in = 0;
            if (c == 42) btn_in = 1;
            if (c == 60) btn_in = 0;
        end
    endtask

    task automatic test_reset_held();
        btn_in = 1;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            tests++;
            if (step !== (c == 6 || c == 27 || c == 37)) begin
                fails++;
                $display("FAIL rsthold_step cyc %0d: got %b", c, step);
            end
            tests++;
            if (repeating !== (c >= 27 && c < 31)) begin
                fails++;
                $display("FAIL rsthold_repeating cyc %0d: got %b expected %b", c, repeating, (c >= 27 && c < 31));
            end
            if (c == 31) begin
                tests++;
                if ({step, pressed, repeating} !== 3'b000) begin
                    fails++;
                    $display("FAIL rsthold_cleared: got %b%b%b expected 000", step, pressed, repeating);
                end
            end
            tests++;
            if ({step, pressed, repeating} !== {e_step, m_pressed, m_rep}) begin
                fails++;
                $display("FAIL rsthold_model cyc %0d: got %b%b%b expected %b%b%b", c, step, pressed, repeating, e_step, m_pressed, m_rep);
            end
            if (c == 30) rst = 1;
            if (c == 31) rst = 0;
            if (c == 40) btn_in = 0;
        end
    endtask

    task automatic test_random();
        int   seg = 1;
        logic prev_step = 0;
        for (int c = 1; c <= 1500; c++) begin
            @(negedge clk);
            tests++;
            if ({step, pressed, repeating} !== {e_step, m_pressed, m_rep}) begin
                fails++;
                $display("FAIL random_model cyc %0d: got %b%b%b expected %b%b%b", c, step, pressed, repeating, e_step, m_pressed, m_rep);
            end
            tests++;
            if (prev_step === 1'b1 && step === 1'b1) begin
                fails++;
                $display("FAIL random_double_step cyc %0d: got 1 after 1 expected 0", c);
            end
            prev_step = step;
            seg--;
            if (seg == 0) begin
                btn_in = ~btn_in;
                seg = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 0;
        btn_in = 0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_glitch();
        test_reset_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
